qcw_ramp_sequencer: RTL and testbench
=====================================

QCW_RAMP_SEQUENCER -- requirements
Module: qcw_ramp_sequencer

Interface
REQ-001 The block SHALL be an upstream burst sequencer feeding qcw_driver (start, halt, phase_shift, cycle_limit) and consuming its ready and cycle_finished.
REQ-002 Parameter PHASE_MIN, default 50, SHALL be the lowest phase code ever driven.
REQ-003 Parameter PHASE_MAX, default 254, SHALL be the highest phase code ever driven.
REQ-004 Parameter ACCEPT_TIMEOUT, default 1024, SHALL be the clocks allowed for the driver to drop ready after start.
REQ-005 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port trigger, input, 1: burst request, already synchronous to clk.
REQ-008 Port ramp_start / ramp_end, input, 8 each: first and final phase code of the ramp.
REQ-009 Port ramp_step_cycles, input, 8: driver cycles per one-code ramp step; 0 is treated as 1.
REQ-010 Port pulse_cycles, input, 16: burst length in driver cycles.
REQ-011 Port holdoff_clks, input, 24: minimum idle clocks between bursts.
REQ-012 Port drv_ready / drv_cycle_finished, input, 1 each: ready and cycle_finished from the driver.
REQ-013 Port ocd, input, 1: overcurrent flag (used only when QCW_RAMP_OCD_EN is defined).
REQ-014 Port drv_start / drv_halt, output, 1 each: single-clock pulses to the driver.
REQ-015 Port drv_phase_shift, output, 8: the current ramp phase code.
REQ-016 Port drv_cycle_limit, output, 16: the latched pulse_cycles.
REQ-017 Port busy, output, 1: high in every state except IDLE.
REQ-018 Port fault, output, 1: latched fault indicator.

Function
REQ-019 States SHALL be IDLE, ARM, ACCEPT, RUN, DRAIN, HOLDOFF and FAULT.
REQ-020 IDLE: a rising edge of trigger (registered previous value) with drv_ready=1 SHALL latch all configuration inputs, clamp both ramp endpoints to [PHASE_MIN, PHASE_MAX], load drv_phase_shift with the clamped ramp_start, and go to ARM.
REQ-021 IDLE: a trigger edge with drv_ready=0 SHALL be ignored.
REQ-022 ARM: drv_start SHALL be asserted for exactly one clock; the next state is ACCEPT.
REQ-023 ACCEPT: drv_ready=0 SHALL go to RUN; ACCEPT_TIMEOUT clocks without it SHALL go to FAULT.
REQ-024 RUN: each drv_cycle_finished SHALL increment a 16-bit burst counter and an 8-bit step counter.
REQ-025 RUN: when the step counter reaches the latched ramp_step_cycles, the step counter SHALL clear and drv_phase_shift SHALL move one code toward ramp_end, never passing it; the ramp may rise or fall.
REQ-026 RUN: the burst counter reaching the latched pulse_cycles SHALL go to DRAIN without asserting halt.
REQ-027 RUN: a falling edge of trigger SHALL pulse drv_halt for one clock and go to DRAIN (early termination).
REQ-028 DRAIN: drv_ready=1 SHALL go to HOLDOFF, and the holdoff counter SHALL be loaded with the latched holdoff_clks.
REQ-029 HOLDOFF: the counter SHALL decrement each clock and the block SHALL return to IDLE at 0; holdoff_clks=0 SHALL give IDLE on the next clock.
REQ-030 Trigger edges in any state other than IDLE SHALL be ignored and not queued.
REQ-031 FAULT: drv_halt SHALL pulse on entry, fault SHALL be held at 1, and the block SHALL return to IDLE only when trigger=0 and drv_ready=1, clearing fault at that point.
REQ-032 Configuration input changes during a burst SHALL NOT affect that burst.
REQ-033 When a step and a burst end occur on the same drv_cycle_finished, the burst end SHALL take priority and the phase code SHALL be left unchanged.
REQ-034 Latency from the trigger edge to drv_start SHALL be 2 clocks (IDLE→ARM, then the pulse).

Reset
REQ-035 rst=1 SHALL immediately force IDLE and clear all counters.
REQ-036 During reset, drv_start=0, drv_halt=0, busy=0 and fault=0.
REQ-037 During reset, drv_phase_shift SHALL be PHASE_MIN and drv_cycle_limit SHALL be 0.
REQ-038 The registered previous value of trigger SHALL reset to 1, so a trigger already high at reset release does not fire.
REQ-039 A reset during RUN SHALL NOT pulse drv_halt.

Configuration
REQ-040 With QCW_RAMP_OCD_EN defined, ocd=1 in ARM, ACCEPT or RUN SHALL pulse drv_halt and go to FAULT within 1 clock.
REQ-041 Without QCW_RAMP_OCD_EN, ocd SHALL be ignored and the FAULT state SHALL be reachable only through the ACCEPT timeout.

Verification
REQ-042 ramp_start=60, ramp_end=70, step=2, pulse=30, trigger held high → drv_phase_shift reaches 70 after 20 finished cycles and holds; no drv_halt; busy returns to 0 after holdoff.
REQ-043 ramp_start=200, ramp_end=20 → ramp descends from 200 and saturates at 50 (PHASE_MIN).
REQ-044 trigger falls after 5 finished cycles → one drv_halt pulse; DRAIN; IDLE after holdoff_clks+1 clocks following drv_ready=1.
REQ-045 drv_ready held at 1 after drv_start → FAULT after 1024 clocks; fault=1 until trigger=0 and drv_ready=1.
REQ-046 With QCW_RAMP_OCD_EN defined, ocd pulsed during RUN → drv_halt on the next clock and fault=1; without the macro → no effect.
REQ-047 rst asserted mid-RUN → all outputs at reset values at once; trigger still high after release → no drv_start.

Source files
------------

// File: rtl/qcw_ramp_sequencer.sv
// Burst sequencer in front of qcw_driver: starts a burst, ramps the phase code, drains, holds off.
// Define QCW_RAMP_OCD_EN to let the ocd input abort a burst into FAULT.
module qcw_ramp_sequencer #(
    parameter int unsigned PHASE_MIN      = 50,
    parameter int unsigned PHASE_MAX      = 254,
    parameter int unsigned ACCEPT_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger,
    input  logic [7:0]  ramp_start,
    input  logic [7:0]  ramp_end,
    input  logic [7:0]  ramp_step_cycles,
    input  logic [15:0] pulse_cycles,
    input  logic [23:0] holdoff_clks,
    input  logic        drv_ready,
    input  logic        drv_cycle_finished,
    input  logic        ocd,
    output logic        drv_start,
    output logic        drv_halt,
    output logic [7:0]  drv_phase_shift,
    output logic [15:0] drv_cycle_limit,
    output logic        busy,
    output logic        fault
);
    localparam int unsigned PW = 8;
    localparam int unsigned CW = 16;
    localparam int unsigned HW = 24;
    localparam int unsigned TW = $clog2(ACCEPT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_ACCEPT, S_RUN, S_DRAIN, S_HOLDOFF, S_FAULT
    } state_e;

    state_e          state_q, state_d;
    logic            trig_prev_q, trig_prev_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [PW-1:0]   end_q, end_d;
    logic [PW-1:0]   step_cfg_q, step_cfg_d;
    logic [CW-1:0]   limit_q, limit_d;
    logic [HW-1:0]   hold_cfg_q, hold_cfg_d;
    logic [CW-1:0]   burst_q, burst_d;
    logic [PW-1:0]   step_q, step_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            drv_start_q, drv_start_d;
    logic            drv_halt_q, drv_halt_d;
    logic            busy_q, busy_d;
    logic            fault_q, fault_d;

    logic            trig_rise_c;
    logic            trig_fall_c;
    logic [CW-1:0]   burst_n_c;
    logic [PW-1:0]   step_n_c;
    logic            burst_end_c;

    function automatic logic [PW-1:0] clamp_phase(input logic [PW-1:0] x);
        if (32'(x) < 32'(PHASE_MIN)) return PW'(PHASE_MIN);
        if (32'(x) > 32'(PHASE_MAX)) return PW'(PHASE_MAX);
        return x;
    endfunction

    assign trig_rise_c = trigger & ~trig_prev_q;
    assign trig_fall_c = ~trigger & trig_prev_q;
    assign burst_n_c   = burst_q + CW'(1);
    assign step_n_c    = step_q + PW'(1);
    assign burst_end_c = drv_cycle_finished && (burst_n_c == limit_q);

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        trig_prev_d = trigger;
        phase_d     = phase_q;
        end_d       = end_q;
        step_cfg_d  = step_cfg_q;
        limit_d     = limit_q;
        hold_cfg_d  = hold_cfg_q;
        burst_d     = burst_q;
        step_d      = step_q;
        hold_d      = hold_q;
        tmo_d       = tmo_q;
        drv_start_d = 1'b0;
        drv_halt_d  = 1'b0;
        fault_d     = fault_q;

        case (state_q)
            S_IDLE: begin
                if (trig_rise_c && drv_ready) begin
                    phase_d    = clamp_phase(ramp_start);
                    end_d      = clamp_phase(ramp_end);
                    step_cfg_d = (ramp_step_cycles == PW'(0)) ? PW'(1) : ramp_step_cycles;
                    limit_d    = pulse_cycles;
                    hold_cfg_d = holdoff_clks;
                    state_d    = S_ARM;
                end
            end
            S_ARM: begin
                drv_start_d = 1'b1;
                tmo_d       = '0;
                state_d     = S_ACCEPT;
            end
            S_ACCEPT: begin
                if (!drv_ready) begin
                    burst_d = '0;
                    step_d  = '0;
                    state_d = S_RUN;
                end else if (tmo_q == TW'(ACCEPT_TIMEOUT - 1)) begin
                    drv_halt_d = 1'b1;
                    fault_d    = 1'b1;
                    state_d    = S_FAULT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RUN: begin
                // A finishing burst wins over both a ramp step and an early stop.
                if (burst_end_c) begin
                    burst_d = burst_n_c;
                    state_d = S_DRAIN;
                end else begin
                    if (drv_cycle_finished) begin
                        burst_d = burst_n_c;
                        if (step_n_c == step_cfg_q) begin
                            step_d = '0;
                            if (phase_q < end_q)      phase_d = phase_q + PW'(1);
                            else if (phase_q > end_q) phase_d = phase_q - PW'(1);
                        end else begin
                            step_d = step_n_c;
                        end
                    end
                    if (trig_fall_c) begin
                        drv_halt_d = 1'b1;
                        state_d    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drv_ready) begin
                    hold_d  = hold_cfg_q;
                    state_d = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (hold_q == HW'(0)) state_d = S_IDLE;
                else                  hold_d  = hold_q - HW'(1);
            end
            S_FAULT: begin
                if (!trigger && drv_ready) begin
                    fault_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef QCW_RAMP_OCD_EN
        if (ocd && (state_q == S_ARM || state_q == S_ACCEPT || state_q == S_RUN)) begin
            drv_start_d = 1'b0;
            drv_halt_d  = 1'b1;
            fault_d     = 1'b1;
            state_d     = S_FAULT;
        end
`endif

        busy_d = (state_d != S_IDLE);
    end

`ifndef QCW_RAMP_OCD_EN
    logic ocd_unused;
    assign ocd_unused = ocd;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            trig_prev_q <= 1'b1;
            phase_q     <= PW'(PHASE_MIN);
            end_q       <= PW'(PHASE_MIN);
            step_cfg_q  <= PW'(1);
            limit_q     <= '0;
            hold_cfg_q  <= '0;
            burst_q     <= '0;
            step_q      <= '0;
            hold_q      <= '0;
            tmo_q       <= '0;
            drv_start_q <= 1'b0;
            drv_halt_q  <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_prev_q <= trig_prev_d;
            phase_q     <= phase_d;
            end_q       <= end_d;
            step_cfg_q  <= step_cfg_d;
            limit_q     <= limit_d;
            hold_cfg_q  <= hold_cfg_d;
            burst_q     <= burst_d;
            step_q      <= step_d;
            hold_q      <= hold_d;
            tmo_q       <= tmo_d;
            drv_start_q <= drv_start_d;
            drv_halt_q  <= drv_halt_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
        end
    end

    assign drv_start       = drv_start_q;
    assign drv_halt        = drv_halt_q;
    assign drv_phase_shift = phase_q;
    assign drv_cycle_limit = limit_q;
    assign busy            = busy_q;
    assign fault           = fault_q;

endmodule

// File: tb/tb_qcw_ramp_sequencer.sv
// Scoreboard bench for qcw_ramp_sequencer: stimulus plays the driver and queues expected events,
// a monitor pops and compares each event the sequencer presents.
`timescale 1ns/1ps
module tb_qcw_ramp_sequencer;
    localparam int PMIN = 50;
    localparam int PMAX = 254;
    localparam int TOUT = 1024;
    localparam int K_START = 0, K_PHASE = 1, K_HALT = 2, K_FAULT = 3, K_IDLE = 4;

    typedef struct { int kind; int v0; int v1; } exp_t;
    exp_t exp_q[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trigger = 1'b0;
    logic [7:0]  ramp_start = 8'd0;
    logic [7:0]  ramp_end = 8'd0;
    logic [7:0]  ramp_step_cycles = 8'd0;
    logic [15:0] pulse_cycles = 16'd0;
    logic [23:0] holdoff_clks = 24'd0;
    logic        drv_ready = 1'b1;
    logic        drv_cycle_finished = 1'b0;
    logic        ocd = 1'b0;
    logic        drv_start, drv_halt, busy, fault;
    logic [7:0]  drv_phase_shift;
    logic [15:0] drv_cycle_limit;

    int n_total = 0;
    int n_pass  = 0;

    qcw_ramp_sequencer #(.PHASE_MIN(PMIN), .PHASE_MAX(PMAX), .ACCEPT_TIMEOUT(TOUT)) dut (
        .clk(clk), .rst(rst), .trigger(trigger),
        .ramp_start(ramp_start), .ramp_end(ramp_end), .ramp_step_cycles(ramp_step_cycles),
        .pulse_cycles(pulse_cycles), .holdoff_clks(holdoff_clks),
        .drv_ready(drv_ready), .drv_cycle_finished(drv_cycle_finished), .ocd(ocd),
        .drv_start(drv_start), .drv_halt(drv_halt), .drv_phase_shift(drv_phase_shift),
        .drv_cycle_limit(drv_cycle_limit), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    function automatic string kname(input int k);
        case (k)
            K_START: return "start";
            K_PHASE: return "phase";
            K_HALT:  return "halt";
            K_FAULT: return "fault";
            default: return "idle";
        endcase
    endfunction

    // Reference model: phase code after n finished cycles of a ramp from s toward e
    function automatic int clampp(input int x);
        return (x < PMIN) ? PMIN : ((x > PMAX) ? PMAX : x);
    endfunction

    function automatic int phase_after(input int s, input int e, input int stp, input int n);
        int k = n / stp;
        if (e >= s) return s + (((e - s) < k) ? (e - s) : k);
        return s - (((s - e) < k) ? (s - e) : k);
    endfunction

    // Clock count since the stimulus last toggled mark_tog
    logic fin_s = 1'b0;
    logic mark_tog = 1'b0, mark_seen = 1'b0;
    int   mark_clks = 0;
    always @(posedge clk) begin
        fin_s <= drv_cycle_finished & ~rst;
        if (mark_tog != mark_seen) begin
            mark_seen <= mark_tog;
            mark_clks <= 1;
        end else begin
            mark_clks <= mark_clks + 1;
        end
    end

    task automatic expect_event(input int kind, input int a, input int b);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_%s: DUT event with nothing expected (t=%0t)", kname(kind), $time);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind) begin
            check("event_order", kind, e.kind);
            return;
        end
        case (kind)
            K_START: begin
                check("start_phase", a, e.v0);
                check("start_limit", b, e.v1);
            end
            K_PHASE: check("phase", a, e.v0);
            K_HALT:  check("halt_pulse", a, e.v0);
            K_FAULT: check("fault_latency", a, e.v0);
            default: begin
                check("idle_latency", a, e.v0);
                check("idle_fault_clear", b, e.v1);
            end
        endcase
    endtask

    // Monitor
    logic busy_prev = 1'b0, fault_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            busy_prev = 1'b0;
            fault_prev = 1'b0;
        end else begin
            if (drv_start)             expect_event(K_START, int'(drv_phase_shift), int'(drv_cycle_limit));
            if (fin_s)                 expect_event(K_PHASE, int'(drv_phase_shift), 0);
            if (drv_halt)              expect_event(K_HALT, int'(drv_halt), 0);
            if (fault && !fault_prev)  expect_event(K_FAULT, mark_clks, 0);
            if (!busy && busy_prev)    expect_event(K_IDLE, mark_clks, int'(fault));
            busy_prev = busy;
            fault_prev = fault;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input int a, input int b);
        exp_t e;
        e.kind = k; e.v0 = a; e.v1 = b;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick(1);
            c++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic fault_recover();
        drv_ready = 1'b0; trigger = 1'b0;
        tick(4);
        check("fault_hold_not_ready", int'(fault), 1);
        drv_ready = 1'b1; trigger = 1'b1;
        tick(4);
        check("fault_hold_trigger_high", int'(fault), 1);
        push(K_IDLE, 1, 0);
        mark_tog = ~mark_tog; trigger = 1'b0;
        wait_drain("fault_release", 10);
        tick(2);
    endtask

    // One burst with the bench acting as qcw_driver
    task automatic run_burst(input int s, input int e, input int stp, input int pul, input int hold,
                             input int stop_after, input int ocd_at, input bit hang, input bit retrig);
        int cs = clampp(s);
        int ce = clampp(e);
        int se = (stp == 0) ? 1 : stp;
        int nfin, c;
        ramp_start = 8'(s); ramp_end = 8'(e); ramp_step_cycles = 8'(stp);
        pulse_cycles = 16'(pul); holdoff_clks = 24'(hold);
        push(K_START, cs, pul);
        if (hang) begin
            push(K_HALT, 1, 0);
            push(K_FAULT, TOUT + 2, 0);   // 2 clocks to drv_start, then the full accept window
        end
        mark_tog = ~mark_tog; trigger = 1'b1;
        c = 0;
        do begin tick(1); c++; end while (!drv_start && c < 10);
        check("start_latency", c, 2);
        ramp_start = 8'($urandom); ramp_end = 8'($urandom); ramp_step_cycles = 8'($urandom);
        pulse_cycles = 16'($urandom); holdoff_clks = 24'($urandom);
        if (hang) begin
            wait_drain("accept_timeout", TOUT + 20);
            fault_recover();
            return;
        end
        tick($urandom_range(1, 3));
        drv_ready = 1'b0;
        tick(1);
        nfin = (stop_after != 0) ? stop_after : pul;
        for (int i = 1; i <= nfin; i++) begin
            push(K_PHASE, phase_after(cs, ce, se, (i == pul) ? i - 1 : i), 0);
            drv_cycle_finished = 1'b1;
            tick(1);
            drv_cycle_finished = 1'b0;
            if (i == ocd_at) begin
`ifdef QCW_RAMP_OCD_EN
                push(K_HALT, 1, 0);
                push(K_FAULT, 1, 0);
                mark_tog = ~mark_tog;
`endif
                ocd = 1'b1;
                tick(1);
                ocd = 1'b0;
`ifdef QCW_RAMP_OCD_EN
                wait_drain("ocd_fault", 10);
                fault_recover();
                return;
`else
                check("ocd_ignored_busy", int'(busy), 1);
                check("ocd_ignored_fault", int'(fault), 0);
`endif
            end
            if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 2));
        end
        tick(1);
        if (stop_after != 0) begin
            push(K_HALT, 1, 0);
            trigger = 1'b0;
            wait_drain("early_halt", 10);
        end else if (retrig) begin
            trigger = 1'b0;
            tick(1);
            trigger = 1'b1;
        end
        tick($urandom_range(1, 3));
        push(K_IDLE, hold + 2, 0);
        mark_tog = ~mark_tog; drv_ready = 1'b1;
        wait_drain("holdoff_idle", hold + 20);
        trigger = 1'b0;
        tick(2);
    endtask

    int s, e, stp, pul, hold, stop, starts;

    initial begin
        tick(2);
        check("rst_drv_start", int'(drv_start), 0);
        check("rst_drv_halt", int'(drv_halt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_phase", int'(drv_phase_shift), PMIN);
        check("rst_limit", int'(drv_cycle_limit), 0);
        rst = 1'b0;
        tick(2);

        drv_ready = 1'b0; trigger = 1'b1;
        tick(5);
        check("no_fire_not_ready", int'(busy), 0);
        trigger = 1'b0; drv_ready = 1'b1;
        tick(2);

        run_burst(60, 70, 2, 30, 4, 0, 0, 1'b0, 1'b0);
        check("ramp_final_phase", int'(drv_phase_shift), 70);
        run_burst(200, 20, 1, 180, 3, 0, 0, 1'b0, 1'b0);
        check("descend_floor", int'(drv_phase_shift), PMIN);
        run_burst(100, 120, 1, 40, 6, 5, 0, 1'b0, 1'b0);
        run_burst(60, 70, 2, 30, 5, 0, 0, 1'b1, 1'b0);
        run_burst(80, 90, 1, 20, 2, 0, 4, 1'b0, 1'b0);
        run_burst(10, 255, 3, 12, 0, 0, 0, 1'b0, 1'b1);

        for (int n = 0; n < 12; n++) begin
            s = $urandom_range(0, 255);
            e = $urandom_range(0, 255);
            stp = $urandom_range(0, 4);
            pul = $urandom_range(1, 40);
            hold = $urandom_range(0, 20);
            stop = (pul > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, pul - 1) : 0;
            run_burst(s, e, stp, pul, hold, stop, 0, 1'b0, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a burst with trigger left high
        ramp_start = 8'd90; ramp_end = 8'd100; ramp_step_cycles = 8'd1;
        pulse_cycles = 16'd50; holdoff_clks = 24'd3;
        push(K_START, 90, 50);
        trigger = 1'b1;
        tick(4);
        drv_ready = 1'b0;
        tick(1);
        for (int i = 1; i <= 3; i++) begin
            push(K_PHASE, phase_after(90, 100, 1, i), 0);
            drv_cycle_finished = 1'b1;
            tick(1);
            drv_cycle_finished = 1'b0;
        end
        wait_drain("pre_reset", 5);
        tick(1);
        rst = 1'b1;
        #1;
        check("midrun_rst_start", int'(drv_start), 0);
        check("midrun_rst_halt", int'(drv_halt), 0);
        check("midrun_rst_busy", int'(busy), 0);
        check("midrun_rst_fault", int'(fault), 0);
        check("midrun_rst_phase", int'(drv_phase_shift), PMIN);
        check("midrun_rst_limit", int'(drv_cycle_limit), 0);
        tick(2);
        drv_ready = 1'b1;
        tick(1);
        rst = 1'b0;
        starts = 0;
        repeat (20) begin
            tick(1);
            if (drv_start) starts++;
        end
        check("no_start_after_reset", starts, 0);
        check("idle_after_reset", int'(busy), 0);
        trigger = 1'b0;
        tick(5);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
